// File: rtl/axil_counter_pkg.sv
// Shared definitions for the AXI4-Lite counter slave: register map,
// response codes and the write/read channel state types.
package axil_counter_pkg;

  localparam int NUM_REGS = 4;

  localparam logic [4:0] OFS_CTRL  = 5'h00;
  localparam logic [4:0] OFS_REG1  = 5'h04;
  localparam logic [4:0] OFS_REG2  = 5'h08;
  localparam logic [4:0] OFS_REG3  = 5'h0C;
  localparam logic [4:0] OFS_COUNT = 5'h10;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_free_counter.sv
// Free-running 32-bit up-counter with enable and a clear that wins over
// the increment; wraps naturally at 0xFFFFFFFF.
module axil_free_counter
  import axil_counter_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_b,
  input  logic        en,
  input  logic        clr,
  output logic [31:0] count
);

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/axil_counter_slave.sv
// AXI4-Lite slave with four RW registers and a read-only free-running
// counter. Write and read channels run as independent FSMs.
//
// state      | meaning
// WR_IDLE    | no address or data held, both READYs open
// WR_HAVE_AW | write address held, waiting for data
// WR_HAVE_W  | write data held, waiting for address
// WR_RESP    | register updated, BVALID held until BREADY
// RD_IDLE    | ARREADY open
// RD_DATA    | RDATA/RRESP held until RREADY
module axil_counter_slave
  import axil_counter_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     count_o
);

  wr_state_t                         wr_state;
  rd_state_t                         rd_state;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wdata_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb_q;
  logic [31:0]                       regs [NUM_REGS];
  logic                              clr_q;
  logic [31:0]                       count;

  logic                              aw_hs, w_hs, ar_hs, wr_fire, wr_mapped;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0]     wr_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   wr_strb;
  logic [2:0]                        wr_idx, rd_idx;
  logic                              rd_mapped;
  logic [31:0]                       rd_val;

  always_comb begin
    aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
    w_hs    = S_AXI_WVALID & S_AXI_WREADY;
    ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
    wr_fire = 1'b0;
    case (wr_state)
      WR_IDLE:    wr_fire = aw_hs & w_hs;
      WR_HAVE_AW: wr_fire = w_hs;
      WR_HAVE_W:  wr_fire = aw_hs;
      default:    wr_fire = 1'b0;
    endcase
    // Whichever half arrived earlier comes from its holding register.
    wr_addr   = (wr_state == WR_HAVE_AW) ? awaddr_q : S_AXI_AWADDR;
    wr_data   = (wr_state == WR_HAVE_W)  ? wdata_q  : S_AXI_WDATA;
    wr_strb   = (wr_state == WR_HAVE_W)  ? wstrb_q  : S_AXI_WSTRB;
    wr_idx    = wr_addr[4:2];
    wr_mapped = (wr_idx < 3'(NUM_REGS));
  end

  always_comb begin
    rd_idx    = S_AXI_ARADDR[4:2];
    rd_mapped = (rd_idx <= OFS_COUNT[4:2]);
    rd_val    = '0;
    if (rd_idx < 3'(NUM_REGS)) begin
      rd_val = regs[rd_idx[1:0]];
    end else if (rd_idx == OFS_COUNT[4:2]) begin
      rd_val = count;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_state      <= WR_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else if (wr_fire) begin
      wr_state      <= WR_RESP;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b1;
      S_AXI_BRESP   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          S_AXI_AWREADY <= !aw_hs;
          S_AXI_WREADY  <= !w_hs;
          if (aw_hs) begin
            awaddr_q <= S_AXI_AWADDR;
            wr_state <= WR_HAVE_AW;
          end else if (w_hs) begin
            wdata_q  <= S_AXI_WDATA;
            wstrb_q  <= S_AXI_WSTRB;
            wr_state <= WR_HAVE_W;
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            wr_state      <= WR_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      clr_q <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      if (wr_fire && wr_mapped) begin
        regs[wr_idx[1:0]] <= apply_strb(regs[wr_idx[1:0]], wr_data, wr_strb);
        // The clear bit is a strobe: it is never stored, so CTRL reads it as 0.
        if (wr_idx == OFS_CTRL[4:2]) begin
          regs[0][CTRL_CLR_BIT] <= 1'b0;
          clr_q <= wr_strb[0] & wr_data[CTRL_CLR_BIT];
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_state      <= RD_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            S_AXI_RDATA   <= rd_val;
            S_AXI_RRESP   <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            rd_state      <= RD_DATA;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        RD_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            rd_state      <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  axil_free_counter u_counter (
    .clk_sys (ACLK),
    .rst_b   (ARESETN),
    .en      (regs[0][CTRL_EN_BIT]),
    .clr     (clr_q),
    .count   (count)
  );

  assign count_o = count;

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], wr_addr[1:0]};

endmodule

// File: doc/axil_counter_slave.md
AXIL_COUNTER_SLAVE -- requirements
Module: axil_counter_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, register/data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port ARESETN, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have ports S_AXI_AWADDR in [ADDR_WIDTH], S_AXI_AWPROT in 3, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write address channel (AWPROT ignored).
REQ-006 SHALL have ports S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write data channel.
REQ-007 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response channel.
REQ-008 SHALL have ports S_AXI_ARADDR in [ADDR_WIDTH], S_AXI_ARPROT in 3, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address channel (ARPROT ignored).
REQ-009 SHALL have ports S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data channel.
REQ-010 SHALL have port count_o, output, 32, live counter value.

Function
REQ-011 Register map (word index = addr[4:2]): 0x00 CTRL RW, 0x04 REG1 RW, 0x08 REG2 RW, 0x0C REG3 RW, 0x10 COUNT RO; 0x14-0x1C unmapped.
REQ-012 CTRL[0] = count enable; CTRL[1] = clear strobe, write-1 clears COUNT the following cycle, self-clears, reads 0; CTRL[31:2] plain storage.
REQ-013 COUNT SHALL increment by 1 per cycle while CTRL[0]=1, wrapping 0xFFFFFFFF -> 0; clear takes priority over increment.
REQ-014 Write FSM states: IDLE, HAVE_AW, HAVE_W, RESP; AW and W accepted independently in any order or same cycle.
REQ-015 AWREADY high only when no address is held and FSM not in RESP; WREADY likewise for data.
REQ-016 When both address and data are held, register update SHALL occur on that edge and BVALID rises the next cycle (same-cycle AW+W: BVALID one cycle after handshake).
REQ-017 BVALID and BRESP SHALL hold stable until BREADY; no new AW/W accepted while BVALID=1.
REQ-018 Write byte lanes SHALL honour WSTRB; WSTRB=0 is a legal no-op with OKAY.
REQ-019 Write to COUNT or unmapped address: no state change, BRESP=SLVERR (2'b10); otherwise OKAY.
REQ-020 Read FSM states: IDLE, RDATA; ARREADY high in IDLE only; RVALID rises the cycle after AR handshake with RDATA sampled at that handshake.
REQ-021 RVALID/RDATA/RRESP SHALL hold stable until RREADY; return to IDLE on RREADY.
REQ-022 Unmapped read: RDATA=0, RRESP=SLVERR; mapped read RRESP=OKAY.
REQ-023 Simultaneous read and write to the same register: read returns pre-write value.
REQ-024 Read and write paths SHALL be fully independent; neither stalls the other.

Reset
REQ-025 While ARESETN=0 at a clock edge: all registers and COUNT = 0, AWREADY/WREADY/ARREADY = 0, BVALID/RVALID = 0, BRESP/RRESP = OKAY, RDATA = 0, FSMs IDLE.
REQ-026 Reset mid-transaction SHALL abandon held AW/W/AR and pending responses without emitting them.
REQ-027 READY outputs SHALL go high no earlier than the first edge after ARESETN deasserts.

Structure
REQ-028 Shared package axil_counter_pkg SHALL hold register offsets, RESP encodings (OKAY, SLVERR), write/read FSM state typedefs, NUM_REGS=4.
REQ-029 Counter SHALL be a sub-module axil_free_counter (en, clr, count) instantiated once.

Verification
REQ-030 Write 0x1,0x2,0x3,0x4 to 0x00..0x0C, read back -> 0x1..0x4, all OKAY.
REQ-031 AW three cycles before W, then W before AW -> single register update each, one BVALID per write.
REQ-032 Write 0xAABBCCDD to 0x04 with WSTRB=0b0101 over 0x00000000 -> read 0x00BB00DD.
REQ-033 Write CTRL=1, wait 10 cycles, read COUNT -> value 10 +/- handshake offset, monotonic on second read; write CTRL=2 -> COUNT reads small value restarting from 0.
REQ-034 Write to 0x10 and read 0x18 -> BRESP=SLVERR, RRESP=SLVERR with RDATA=0, COUNT unaffected.
REQ-035 Hold BREADY/RREADY low 5 cycles -> responses stable, no further READY; assert ARESETN=0 mid-write -> BVALID never asserted, all registers 0.
